// File: rtl/snvs_lp_zmk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// snvs_lp_zmk_ctrl_pkg
// Shared SNVS low-power ZMK parameters: default key geometry and the
// controller state encoding. Imported by the ZMK controller.
// ---------------------------------------------------------------------------
package snvs_lp_zmk_ctrl_pkg;

    // Default key geometry: eight 32-bit words make up the 256-bit ZMK.
    localparam int ZMK_WORDS_DEF  = 8;
    localparam int DATA_WIDTH_DEF = 32;

    // Controller states. ZERO clears the datapath, ZCHK verifies it reads zero.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HW_LOAD = 2'd1,
        ST_ZERO    = 2'd2,
        ST_ZCHK    = 2'd3
    } zmk_state_e;

endpackage

// File: rtl/snvs_lp_zmk_ctrl.sv
// ---------------------------------------------------------------------------
// snvs_lp_zmk_ctrl
// Write/zeroize controller for the SNVS low-power Zero-Master-Key register.
// Accepts software word writes or a hardware key load over a valid/ready
// handshake, performs zeroize with a zero-readback check, and keeps a sticky
// software write lock.
//
// Ports
//   ipg_clk         clock
//   zmk_reset_b     asynchronous active-low reset
//   sw_wr/sw_addr/sw_wdata   software word write
//   lock_set        sets the sticky write lock
//   zeroize_req     security-violation zeroize request
//   hw_load_start   starts a hardware key load
//   key_vld/key_data/key_rdy key-source handshake
//   lpzmk_reg       readback from the ZMK datapath
//   write_lpzmk     one-hot word write enables (registered)
//   lp_wdata        datapath write data (registered)
//   zmk_soft_reset  datapath clear pulse (registered)
//   zmk_valid       every word written since the last clear
//   zmk_locked      lock status
//   busy            FSM not in IDLE
//   zeroize_err     sticky, zero-verify failed
//   sw_wr_err       one-cycle pulse, software write rejected
// ---------------------------------------------------------------------------
module snvs_lp_zmk_ctrl
    import snvs_lp_zmk_ctrl_pkg::*;
#(
    parameter int ZMK_WORDS  = ZMK_WORDS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                            ipg_clk,
    input  logic                            zmk_reset_b,
    input  logic                            sw_wr,
    input  logic [$clog2(ZMK_WORDS)-1:0]    sw_addr,
    input  logic [DATA_WIDTH-1:0]           sw_wdata,
    input  logic                            lock_set,
    input  logic                            zeroize_req,
    input  logic                            hw_load_start,
    input  logic                            key_vld,
    input  logic [DATA_WIDTH-1:0]           key_data,
    output logic                            key_rdy,
    input  logic [ZMK_WORDS*DATA_WIDTH-1:0] lpzmk_reg,
    output logic [ZMK_WORDS-1:0]            write_lpzmk,
    output logic [DATA_WIDTH-1:0]           lp_wdata,
    output logic                            zmk_soft_reset,
    output logic                            zmk_valid,
    output logic                            zmk_locked,
    output logic                            busy,
    output logic                            zeroize_err,
    output logic                            sw_wr_err
);

    localparam int             AW        = $clog2(ZMK_WORDS);
    localparam logic [AW-1:0]  LAST_WORD = AW'(ZMK_WORDS - 1);

    zmk_state_e             state;
    zmk_state_e             state_nxt;
    logic [AW-1:0]          word_cnt;
    logic [ZMK_WORDS-1:0]   written_mask;
    logic                   locked;

    logic                   hw_start_ok;
    logic                   key_take;
    logic                   sw_accept;
    logic [ZMK_WORDS-1:0]   write_nxt;
    logic [DATA_WIDTH-1:0]  wdata_nxt;
    logic                   soft_reset_nxt;
    logic                   sw_err_nxt;

    // State register.
    always_ff @(posedge ipg_clk or negedge zmk_reset_b) begin
        if (!zmk_reset_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Zeroize outranks everything in IDLE and aborts a
    // load; ZERO and ZCHK always run to completion, so a request held high
    // simply starts a fresh zeroize once IDLE is reached again.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (zeroize_req) begin
                    state_nxt = ST_ZERO;
                end else if (hw_start_ok) begin
                    state_nxt = ST_HW_LOAD;
                end
            end
            ST_HW_LOAD: begin
                if (zeroize_req) begin
                    state_nxt = ST_ZERO;
                end else if (key_take && (word_cnt == LAST_WORD)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ZERO: state_nxt = ST_ZCHK;
            ST_ZCHK: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode. The values computed here are registered below, so a
    // write decided in one cycle reaches the datapath in the next. A key word
    // presented in the same cycle as a zeroize abort is dropped, and the
    // soft reset is raised only for the cycle the FSM actually sits in ZERO,
    // which keeps it apart from any write enable.
    always_comb begin
        hw_start_ok    = hw_load_start && !locked;
        key_take       = (state == ST_HW_LOAD) && key_vld && !zeroize_req;
        sw_accept      = (state == ST_IDLE) && sw_wr && !locked &&
                         !zeroize_req && !hw_start_ok;
        write_nxt      = '0;
        wdata_nxt      = '0;
        if (sw_accept) begin
            write_nxt = ZMK_WORDS'(1) << sw_addr;
            wdata_nxt = sw_wdata;
        end else if (key_take) begin
            write_nxt = ZMK_WORDS'(1) << word_cnt;
            wdata_nxt = key_data;
        end
        soft_reset_nxt = (state_nxt == ST_ZERO);
        sw_err_nxt     = sw_wr && !sw_accept;
    end

    // Registered datapath outputs.
    always_ff @(posedge ipg_clk or negedge zmk_reset_b) begin
        if (!zmk_reset_b) begin
            write_lpzmk    <= '0;
            lp_wdata       <= '0;
            zmk_soft_reset <= 1'b0;
            sw_wr_err      <= 1'b0;
        end else begin
            write_lpzmk    <= write_nxt;
            lp_wdata       <= wdata_nxt;
            zmk_soft_reset <= soft_reset_nxt;
            sw_wr_err      <= sw_err_nxt;
        end
    end

    // Key word counter, written mask, sticky lock and sticky zeroize error.
    // The counter idles at zero so every load starts from word 0; an abort
    // clears it on the spot. The lock survives zeroize and only reset clears it.
    always_ff @(posedge ipg_clk or negedge zmk_reset_b) begin
        if (!zmk_reset_b) begin
            word_cnt     <= '0;
            written_mask <= '0;
            locked       <= 1'b0;
            zeroize_err  <= 1'b0;
        end else begin
            if (key_take) begin
                word_cnt <= word_cnt + AW'(1);
            end else if ((state != ST_HW_LOAD) || zeroize_req) begin
                word_cnt <= '0;
            end

            if (state == ST_ZERO) begin
                written_mask <= '0;
            end else begin
                written_mask <= written_mask | write_nxt;
            end

            if (lock_set) begin
                locked <= 1'b1;
            end

            if ((state == ST_ZCHK) && (|lpzmk_reg)) begin
                zeroize_err <= 1'b1;
            end
        end
    end

    assign key_rdy    = (state == ST_HW_LOAD);
    assign busy       = (state != ST_IDLE);
    assign zmk_valid  = &written_mask;
    assign zmk_locked = locked;

endmodule

// File: doc/snvs_lp_zmk_ctrl.md
SNVS_LP_ZMK_CTRL -- requirements
Module: snvs_lp_zmk_ctrl

Interface
REQ-001 Parameter ZMK_WORDS, default 8, number of 32-bit ZMK words.
REQ-002 Parameter DATA_WIDTH, default 32, word width.
REQ-003 Ports, with the clock first and the reset second:
- ipg_clk  in  1  system clock; the single clock.
- zmk_reset_b  in  1  asynchronous, active-low reset.
REQ-004 Software write ports:
- sw_wr  in  1  software word-write strobe.
- sw_addr  in  3  word index.
- sw_wdata  in  32  software write data.
- lock_set  in  1  sets the sticky write lock.
REQ-005 Control ports:
- zeroize_req  in  1  security-violation zeroize request.
- hw_load_start  in  1  starts a hardware key load.
REQ-006 Key-source handshake ports:
- key_vld  in  1  key word valid.
- key_data  in  32  key word.
- key_rdy  out  1  controller accepts a key word.
REQ-007 Datapath ports:
- lpzmk_reg  in  256  readback from the ZMK datapath.
- write_lpzmk  out  8  one-hot word write enables.
- lp_wdata  out  32  datapath write data.
- zmk_soft_reset  out  1  datapath clear pulse.
REQ-008 Status ports:
- zmk_valid  out  1  all words written since the last clear.
- zmk_locked  out  1  lock status.
- busy  out  1  FSM not in IDLE.
- zeroize_err  out  1  sticky; zero-verify failed.
- sw_wr_err  out  1  one-cycle pulse; software write rejected.

Function
REQ-009 The FSM SHALL have the states IDLE, HW_LOAD, ZERO and ZCHK, with all datapath outputs registered.
REQ-010 In IDLE, the following priority SHALL apply:
- zeroize_req goes to ZERO;
- else hw_load_start with the lock clear goes to HW_LOAD;
- else sw_wr is serviced.
REQ-011 A software write accepted in cycle N SHALL drive write_lpzmk[sw_addr]=1 and lp_wdata=sw_wdata for exactly cycle N+1, and SHALL set written-mask bit sw_addr.
REQ-012 sw_wr SHALL be rejected, with sw_wr_err pulsed in cycle N+1, in these cases:
- when locked;
- when not in IDLE;
- when it loses priority in IDLE.
A rejected sw_wr SHALL assert no write_lpzmk bit.
REQ-013 In HW_LOAD, key_rdy SHALL be 1, and a 3-bit word counter SHALL start at 0.
REQ-014 Each key_vld&key_rdy cycle in HW_LOAD SHALL write key_data to word[counter] with one-cycle latency (same timing as REQ-011), set that mask bit and increment the counter.
REQ-015 After the word-7 handshake in HW_LOAD, the FSM SHALL return to IDLE and key_rdy SHALL deassert in the next cycle.
REQ-016 zeroize_req in HW_LOAD SHALL abort the load: the FSM goes to ZERO, the key word of that same cycle is not written, and the counter clears.
REQ-017 ZERO SHALL last one cycle with zmk_soft_reset=1 and write_lpzmk=0, and SHALL clear the written mask.
REQ-018 The next state after ZERO SHALL be ZCHK.
REQ-019 ZCHK SHALL last one cycle and compare lpzmk_reg to zero; a nonzero value SHALL set zeroize_err. The FSM then goes to IDLE.
REQ-020 zeroize_req SHALL be ignored while in ZERO or ZCHK; if it is still high on return to IDLE, a new zeroize SHALL start.
REQ-021 zmk_valid SHALL equal the AND of the 8-bit written mask.
REQ-022 zmk_locked SHALL set on lock_set and clear only on reset; it SHALL NOT be cleared by zeroize.
REQ-023 While locked, hw_load_start SHALL be ignored; zeroize SHALL remain allowed.
REQ-024 zmk_soft_reset and write_lpzmk SHALL never be nonzero in the same cycle.
REQ-025 busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-026 Asserting zmk_reset_b low SHALL immediately force the following, including mid-load or mid-zeroize:
- the FSM to IDLE;
- the counter, mask, lock and zeroize_err to 0;
- all outputs to 0.
REQ-027 After reset release, the first accepted command SHALL be sampled at the first rising ipg_clk edge.

Structure
REQ-028 The state encoding, ZMK_WORDS and DATA_WIDTH SHALL reside in the shared SNVS parameter include.
REQ-029 No sub-module SHALL be used; the controller SHALL be a single module feeding the ZMK datapath block directly.

Verification
REQ-030 Software write: sw_wr with sw_addr=3 and sw_wdata=0xDEADBEEF -> next cycle write_lpzmk=0x08 and lp_wdata=0xDEADBEEF; zmk_valid stays 0.
REQ-031 Hardware load: 8 handshakes of data 0x11111111..0x88888888 with gaps on key_vld -> eight one-hot writes 0x01..0x80, then IDLE, zmk_valid=1 and key_rdy=0.
REQ-032 Abort and zeroize:
- zeroize_req after 4 key words -> word 4 not written, then ZERO, ZCHK with readback 0, IDLE;
- zeroize_err stays 0 and zmk_valid=0.
REQ-033 Stuck bit: readback 0x1 in ZCHK -> zeroize_err=1 and it remains set through later zeroizes.
REQ-034 Lock, collision and reset:
- lock_set then sw_wr -> sw_wr_err pulse and no write;
- hw_load_start while locked -> ignored;
- zeroize_req with sw_wr in IDLE -> zeroize wins and sw_wr_err pulses;
- reset asserted in HW_LOAD -> all outputs 0 immediately.
